// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_ctrl_pkg;

    localparam int NUM_IRQ = 8;

    localparam int unsigned OFS_PRI  = 0;
    localparam int unsigned OFS_ENA  = 1;
    localparam int unsigned OFS_FLAG = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } irq_state_t;

    // Two sources share each group, so the group field sits at bit (i/2)*2.
    function automatic logic [1:0] group_prio(input logic [7:0] pri, input int src);
        return pri[(src / 2) * 2 +: 2];
    endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// Combinational winner selection: highest group priority, then lower group,
// then lower source index. Priority 0 never wins.
module irq_prio_encoder
    import irq_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [7:0]         pri,
    output logic               valid,
    output logic [2:0]         winner
);

    always_comb begin
        valid  = 1'b0;
        winner = 3'd0;
        for (int p = 3; p >= 1; p--) begin
            for (int s = 0; s < NUM_IRQ; s++) begin
                if (!valid && eligible[s] && (group_prio(pri, s) == 2'(p))) begin
                    valid  = 1'b1;
                    winner = 3'(s);
                end
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller with PRI/ENA/FLAG registers and a
// REQ/ACK handshake. Define IRQ_CTRL_NMI_EN to make source 0 non-maskable.
module irq_controller #(
    parameter logic [23:0] BASE_ADDR   = 24'h2020,
    parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  irq_in,
    input  logic [1:0]  cpu_ipl,
    output logic        cpu_irq_req,
    output logic [7:0]  cpu_irq_vector,
    input  logic        cpu_irq_ack
);

    import irq_ctrl_pkg::*;

    localparam logic [23:0] PRI_ADDR  = BASE_ADDR + 24'(OFS_PRI);
    localparam logic [23:0] ENA_ADDR  = BASE_ADDR + 24'(OFS_ENA);
    localparam logic [23:0] FLAG_ADDR = BASE_ADDR + 24'(OFS_FLAG);

    logic [7:0]         pri_q, ena_q, flag_q;
    logic [7:0]         flag_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               enc_valid, win_valid;
    logic [2:0]         enc_idx, win_idx;
    logic [2:0]         idx_q, idx_d;
    irq_state_t         state_q, state_d;
    logic               ack_clr;
    logic               wr_pri, wr_ena, wr_flag;

    assign wr_pri  = bus_write && (bus_address_in == PRI_ADDR);
    assign wr_ena  = bus_write && (bus_address_in == ENA_ADDR);
    assign wr_flag = bus_write && (bus_address_in == FLAG_ADDR);

    always_comb begin
        bus_data_out = 8'h00;
        if (bus_read) begin
            if (bus_address_in == PRI_ADDR)       bus_data_out = pri_q;
            else if (bus_address_in == ENA_ADDR)  bus_data_out = ena_q;
            else if (bus_address_in == FLAG_ADDR) bus_data_out = flag_q;
        end
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = flag_q[i] && ena_q[i] && (group_prio(pri_q, i) > cpu_ipl);
        end
`ifdef IRQ_CTRL_NMI_EN
        eligible[0] = flag_q[0];
`endif
    end

    irq_prio_encoder u_encoder (
        .eligible (eligible),
        .pri      (pri_q),
        .valid    (enc_valid),
        .winner   (enc_idx)
    );

`ifdef IRQ_CTRL_NMI_EN
    // The NMI pre-empts arbitration regardless of its group priority.
    assign win_valid = enc_valid || eligible[0];
    assign win_idx   = eligible[0] ? 3'd0 : enc_idx;
`else
    assign win_valid = enc_valid;
    assign win_idx   = enc_idx;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ack_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    idx_d   = win_idx;
                end
            end
            REQ: begin
                if (cpu_irq_ack) begin
                    state_d = ACKD;
                    ack_clr = 1'b1;
                end else if (!eligible[idx_q]) begin
                    state_d = IDLE;
                end
            end
            ACKD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // New pulses are OR-ed in after clearing, so a same-edge set beats any clear.
    always_comb begin
        flag_clr = wr_flag ? bus_data_in : 8'h00;
        if (ack_clr) flag_clr[idx_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q   <= 8'h00;
            ena_q   <= 8'h00;
            flag_q  <= 8'h00;
            state_q <= IDLE;
            idx_q   <= 3'd0;
        end else if (clk_ce) begin
            if (wr_pri) pri_q <= bus_data_in;
            if (wr_ena) ena_q <= bus_data_in;
            flag_q  <= (flag_q & ~flag_clr) | irq_in;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign cpu_irq_req    = (state_q == REQ);
    assign cpu_irq_vector = VECTOR_BASE + {5'b0, idx_q};

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (default build, or with IRQ_CTRL_NMI_EN).
module tb_irq_controller;

    logic        clk;
    logic        reset_n;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [7:0]  irq_in;
    logic [1:0]  cpu_ipl;
    logic        cpu_irq_req;
    logic [7:0]  cpu_irq_vector;
    logic        cpu_irq_ack;

    int n_compared;
    int n_mismatched;

    localparam logic [23:0] BASE = 24'h2020;

    irq_controller #(
        .BASE_ADDR   (24'h2020),
        .VECTOR_BASE (8'h03)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_in         (irq_in),
        .cpu_ipl        (cpu_ipl),
        .cpu_irq_req    (cpu_irq_req),
        .cpu_irq_vector (cpu_irq_vector),
        .cpu_irq_ack    (cpu_irq_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    // Inputs change on negedge; one tick advances through a posedge back to a negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input int unsigned ofs, input logic [7:0] data);
        bus_write      = 1'b1;
        bus_address_in = BASE + 24'(ofs);
        bus_data_in    = data;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic read_reg(input int unsigned ofs, output logic [7:0] data);
        bus_read       = 1'b1;
        bus_address_in = BASE + 24'(ofs);
        #1;
        data           = bus_data_out;
        bus_read       = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] mask);
        irq_in = mask;
        tick();
        irq_in = 8'h00;
    endtask

    task automatic ack_cycle(input logic [7:0] also_irq);
        cpu_irq_ack = 1'b1;
        irq_in      = also_irq;
        tick();
        cpu_irq_ack = 1'b0;
        irq_in      = 8'h00;
    endtask

    initial begin
        logic [7:0] rd;
        n_compared     = 0;
        n_mismatched   = 0;
        reset_n        = 1'b0;
        clk_ce         = 1'b1;
        bus_write      = 1'b0;
        bus_read       = 1'b0;
        bus_address_in = 24'h0;
        bus_data_in    = 8'h00;
        irq_in         = 8'h00;
        cpu_ipl        = 2'd0;
        cpu_irq_ack    = 1'b0;

        #2;
        check_output("reset_req", {7'b0, cpu_irq_req}, 8'h00);
        check_output("reset_vector", cpu_irq_vector, 8'h03);
        read_reg(0, rd); check_output("reset_pri", rd, 8'h00);
        read_reg(1, rd); check_output("reset_ena", rd, 8'h00);
        read_reg(2, rd); check_output("reset_flag", rd, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single source on group 1.
        write_reg(0, 8'h04);
        write_reg(1, 8'h04);
        read_reg(0, rd); check_output("pri_readback", rd, 8'h04);
        read_reg(3, rd); check_output("unmapped_read", rd, 8'h00);
        pulse_irq(8'h04);
        read_reg(2, rd); check_output("t1_flag_set", rd, 8'h04);
        check_output("t1_req_edge1", {7'b0, cpu_irq_req}, 8'h00);
        tick();
        check_output("t1_req_edge2", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t1_vector", cpu_irq_vector, 8'h05);
        ack_cycle(8'h00);
        check_output("t1_req_after_ack", {7'b0, cpu_irq_req}, 8'h00);
        read_reg(2, rd); check_output("t1_flag_cleared", rd, 8'h00);
        tick();

        // Group 1 (prio 3) beats group 3 (prio 1).
        write_reg(0, 8'h4E);
        write_reg(1, 8'hFF);
        pulse_irq(8'h44);
        tick();
        check_output("t2_first_vector", cpu_irq_vector, 8'h05);
        check_output("t2_first_req", {7'b0, cpu_irq_req}, 8'h01);
        ack_cycle(8'h00);
        read_reg(2, rd); check_output("t2_flag_after_ack", rd, 8'h40);
        tick();
        tick();
        check_output("t2_second_req", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t2_second_vector", cpu_irq_vector, 8'h09);
        ack_cycle(8'h00);
        tick();

        // Withdrawal by W1C while requesting.
        write_reg(0, 8'h08);
        pulse_irq(8'h08);
        tick();
        check_output("t3_req", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t3_vector", cpu_irq_vector, 8'h06);
        write_reg(2, 8'h08);
        read_reg(2, rd); check_output("t3_flag_w1c", rd, 8'h00);
        tick();
        check_output("t3_withdrawn", {7'b0, cpu_irq_req}, 8'h00);
        tick();
        check_output("t3_stays_idle", {7'b0, cpu_irq_req}, 8'h00);

        // Priority not above ipl blocks the request until ipl drops.
        write_reg(0, 8'h01);
        write_reg(1, 8'h02);
        cpu_ipl = 2'd1;
        pulse_irq(8'h02);
        tick();
        tick();
        check_output("t4_masked_by_ipl", {7'b0, cpu_irq_req}, 8'h00);
        read_reg(2, rd); check_output("t4_flag", rd, 8'h02);
        cpu_ipl = 2'd0;
        tick();
        check_output("t4_req", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t4_vector", cpu_irq_vector, 8'h04);
        ack_cycle(8'h00);
        tick();

        // Ack and a new pulse on the same source in one cycle: set wins.
        write_reg(0, 8'h10);
        write_reg(1, 8'h10);
        pulse_irq(8'h10);
        tick();
        check_output("t5_req", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t5_vector", cpu_irq_vector, 8'h07);
        ack_cycle(8'h10);
        read_reg(2, rd); check_output("t5_flag_kept", rd, 8'h10);
        check_output("t5_ackd_req", {7'b0, cpu_irq_req}, 8'h00);
        tick();
        tick();
        check_output("t5_rerequest", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t5_rerequest_vector", cpu_irq_vector, 8'h07);
        ack_cycle(8'h00);
        tick();

        // Source 0 with everything masked.
        write_reg(0, 8'h00);
        write_reg(1, 8'h00);
        cpu_ipl = 2'd3;
        pulse_irq(8'h01);
        tick();
`ifdef IRQ_CTRL_NMI_EN
        check_output("t6_nmi_req", {7'b0, cpu_irq_req}, 8'h01);
        check_output("t6_nmi_vector", cpu_irq_vector, 8'h03);
`else
        check_output("t6_nmi_req", {7'b0, cpu_irq_req}, 8'h00);
`endif
        write_reg(2, 8'h01);
        tick();
        cpu_ipl = 2'd0;
        check_output("t6_cleanup_req", {7'b0, cpu_irq_req}, 8'h00);

        // Clock enable low: neither writes nor pulses take effect.
        clk_ce = 1'b0;
        write_reg(1, 8'hAA);
        pulse_irq(8'h20);
        clk_ce = 1'b1;
        read_reg(1, rd); check_output("ce_write_ignored", rd, 8'h00);
        read_reg(2, rd); check_output("ce_pulse_ignored", rd, 8'h00);

        // Reset during REQ drops the request at once.
        write_reg(0, 8'h04);
        write_reg(1, 8'h04);
        pulse_irq(8'h04);
        tick();
        check_output("t7_req_before_reset", {7'b0, cpu_irq_req}, 8'h01);
        reset_n = 1'b0;
        #1;
        check_output("t7_req_in_reset", {7'b0, cpu_irq_req}, 8'h00);
        check_output("t7_vector_in_reset", cpu_irq_vector, 8'h03);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check_output("t7_req_after_reset", {7'b0, cpu_irq_req}, 8'h00);
        read_reg(2, rd); check_output("t7_flag_after_reset", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter BASE_ADDR, 24'h2020, bus address of the PRI register; ENA is at +1, FLAG is at +2.
REQ-002 Parameter VECTOR_BASE, 8'h03, vector number presented for source 0.
REQ-003 clk  in  1  system clock; all state changes on posedge, qualified by clk_ce.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clk_ce  in  1  clock enable; no state changes while low.
REQ-006 bus_write / bus_read  in  1 each  CPU bus strobes.
REQ-007 bus_address_in  in  24  bus address.
REQ-008 bus_data_in  in  8  write data.
REQ-009 bus_data_out  out  8  read data; 0 for unmapped addresses.
REQ-010 irq_in  in  8  one-cycle event pulses: [0..2] from timer irqs, [3..7] from other sources.
REQ-011 cpu_ipl  in  2  current CPU interrupt priority level.
REQ-012 cpu_irq_req  out  1  interrupt request to the CPU.
REQ-013 cpu_irq_vector  out  8  vector number, valid while cpu_irq_req is high.
REQ-014 cpu_irq_ack  in  1  CPU accepts the request; sampled only while cpu_irq_req is high.

Function
REQ-015 Source i belongs to group i/2. PRI holds the group priority: [1:0]=g0, [3:2]=g1, [5:4]=g2, [7:6]=g3. Priority 0 disables the group.
REQ-016 ENA[i] masks source i. FLAG[i] latches irq_in[i] regardless of ENA.
REQ-017 A bus write takes effect at the posedge when clk_ce & bus_write & address match. A FLAG write clears each bit written as 1 (W1C).
REQ-018 Reads are combinational from PRI, ENA, FLAG.
REQ-019 Eligible set = FLAG & ENA & (group priority > cpu_ipl).
REQ-020 Winner: highest group priority first; ties go to the lower group index; within a group, the lower source index wins.
REQ-021 State machine IDLE/REQ/ACKD:
- IDLE -> REQ when the eligible set is non-empty; the winner index is latched.
- REQ -> ACKD on cpu_irq_ack; the latched FLAG bit is cleared.
- REQ -> IDLE with no ack if the latched source leaves the eligible set (withdrawal).
- ACKD -> IDLE unconditionally after one cycle.
REQ-022 cpu_irq_req = (state==REQ). cpu_irq_vector = VECTOR_BASE + latched index (8-bit wrap); it is held constant throughout REQ even if a higher-priority source arrives.
REQ-023 Latency: irq_in pulse at clk_ce edge N -> FLAG set at N -> cpu_irq_req high after edge N+1.
REQ-024 Simultaneous set and clear of the same FLAG bit (from W1C or from ack): set wins, so the bit remains 1.
REQ-025 irq_in is ignored for state purposes while clk_ce is low, so pulses must be aligned to clk_ce.

Reset
REQ-026 While reset_n is low, asynchronously:
- PRI=0, ENA=0, FLAG=0, state=IDLE
- cpu_irq_req=0, cpu_irq_vector=VECTOR_BASE, bus_data_out follows the reset register values.
REQ-027 Reset asserted mid-REQ drops cpu_irq_req immediately; no ack is pending after release.

Configuration
REQ-028 Macro IRQ_CTRL_NMI_EN.
- Defined: source 0 is non-maskable. It ignores ENA[0], PRI g0 and cpu_ipl, and wins over every other source. PRI[1:0] still reads back as written.
- Undefined: source 0 is arbitrated like any other source.

Structure
REQ-029 Package irq_ctrl_pkg holds the state enum (IDLE, REQ, ACKD), the register offset constants (PRI=0, ENA=1, FLAG=2) and NUM_IRQ=8.
REQ-030 Sub-module irq_prio_encoder: purely combinational. Inputs: eligible set and PRI. Outputs: valid and 3-bit winner index.

Verification
REQ-031 PRI=8'h04, ENA=8'h04, ipl=0; pulse irq_in[2] -> cpu_irq_req high after 2 edges, vector 8'h05; ack -> FLAG=8'h00, req low.
REQ-032 PRI=8'h4E (g1=3, g3=1), ENA=8'hFF; pulse irq_in[2] and irq_in[6] together -> vector 8'h05 first; after ack, vector 8'h09.
REQ-033 Pending source 3 in REQ (g1=2, ipl=0); write FLAG=8'h08 -> req withdrawn next cycle, no ack needed, returns to IDLE.
REQ-034 PRI g0=1, ipl=1, ENA[1]=1, pulse irq_in[1] -> no request; FLAG reads 8'h02; set ipl=0 -> request with vector 8'h04.
REQ-035 Ack of source 4 in the same cycle as a new irq_in[4] pulse -> FLAG[4] stays 1 and a new request follows ACKD.
REQ-036 With IRQ_CTRL_NMI_EN defined: ENA=0, PRI=0, ipl=3, pulse irq_in[0] -> request with vector 8'h03. With it undefined, no request.
